// File: rtl/r5p_lsu_pkg.sv
// r5p_lsu_pkg: load/store size encoding and beat-0 byte-select helper.
// Shared by r5p_lsu and r5p_lsu_align.
package r5p_lsu_pkg;

  typedef enum logic [2:0] {
    SZ_B = 3'd0,
    SZ_H = 3'd1,
    SZ_W = 3'd2,
    SZ_D = 3'd3,
    SZ_Q = 3'd4
  } ls_sz_t;

  localparam int unsigned SEL_MAX = 64;

  // bytes [off, off+n) clipped to the bus word
  function automatic logic [SEL_MAX-1:0] opsel(
    input logic [2:0]  sz,
    input int unsigned off,
    input int unsigned dsw
  );
    int unsigned n;
    n = 32'd1 << sz;
    opsel = '0;
    for (int unsigned i = 0; i < SEL_MAX; i++)
      opsel[i] = (i >= off) && (i < off + n) && (i < dsw);
  endfunction

endpackage

// File: rtl/r5p_lsu_align.sv
// r5p_lsu_align: combinational byte-lane steering for stores and
// beat concatenation, shift and sign/zero extension for loads.
module r5p_lsu_align
  import r5p_lsu_pkg::*;
#(
  parameter int XW  = 32,
  parameter int DDW = 32,
  parameter int DWW = 2
)(
  input  logic [DWW-1:0] wr_off,
  input  logic [XW-1:0]  wr_dat,
  output logic [DDW-1:0] wr_lo,
  output logic [DDW-1:0] wr_hi,
  input  logic [DWW-1:0] rd_off,
  input  logic [2:0]     rd_sz,
  input  logic           rd_sg,
  input  logic [DDW-1:0] rd_lo,
  input  logic [DDW-1:0] rd_hi,
  output logic [XW-1:0]  rd_dat
);

  logic [2*DDW-1:0] wr_sh;
  logic [XW-1:0]    rd_sh;
  int unsigned      nb;
  logic             sgn;

  assign wr_sh = {{(2*DDW-XW){1'b0}}, wr_dat} << {wr_off, 3'b000};
  assign wr_lo = wr_sh[DDW-1:0];
  assign wr_hi = wr_sh[2*DDW-1:DDW];

  assign rd_sh = XW'({rd_hi, rd_lo} >> {rd_off, 3'b000});

  always_comb begin
    nb  = 32'd1 << rd_sz;
    sgn = 1'b0;
    for (int unsigned i = 0; i < XW/8; i++)
      if (i + 1 == nb) sgn = rd_sh[8*i+7];
    for (int unsigned i = 0; i < XW/8; i++)
      rd_dat[8*i +: 8] = (i < nb) ? rd_sh[8*i +: 8]
                                  : {8{rd_sg & sgn}};
  end

endmodule

// File: rtl/r5p_lsu.sv
// r5p_lsu: one-at-a-time load/store unit driving a req/ack data bus.
// Define R5P_LSU_MISALIGNED_EN to split word-crossing accesses into two beats.
module r5p_lsu
  import r5p_lsu_pkg::*;
#(
  parameter int XW  = 32,
  parameter int DAW = 32,
  parameter int DDW = 32,
  parameter int DSW = DDW/8
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           ctl_vld,
  output logic           ctl_rdy,
  input  logic           ctl_wen,
  input  logic [2:0]     ctl_sz,
  input  logic           ctl_sg,
  input  logic [XW-1:0]  ctl_adr,
  input  logic [XW-1:0]  ctl_wdt,
  output logic           rsp_vld,
  output logic           rsp_err,
  output logic [XW-1:0]  rsp_rdt,
  output logic           ls_req,
  output logic           ls_wen,
  output logic [DAW-1:0] ls_adr,
  output logic [DSW-1:0] ls_sel,
  output logic [DDW-1:0] ls_wdt,
  input  logic [DDW-1:0] ls_rdt,
  input  logic           ls_ack
);

  localparam int DWW = $clog2(DSW);
  localparam int XBW = $clog2(XW/8);
  localparam logic [DAW-1:0] AMSK = ~DAW'(DSW - 1);

  typedef enum logic [1:0] {IDLE, B0, B1, RSP} state_t;

  state_t         state;
  logic           wen_q;
  logic           sg_q;
  logic           err_q;
  ls_sz_t         sz_q;
  logic [DWW-1:0] off_q;

  logic [DWW-1:0] off;
  int unsigned    n;
  logic           err;
  logic [DDW-1:0] wr_lo;
  logic [DDW-1:0] wr_hi;
  logic [DDW-1:0] rd_lo;
  logic [DDW-1:0] rd_hi;
  logic [XW-1:0]  rd_dat;

  assign ctl_rdy = (state == IDLE) & rst;
  assign off     = ctl_adr[DWW-1:0];

  always_comb begin
    n   = 32'd1 << ctl_sz;
    err = ctl_sz > 3'(XBW);
`ifndef R5P_LSU_MISALIGNED_EN
    if ((ctl_adr[3:0] & 4'(n - 1)) != 4'd0) err = 1'b1;
`endif
  end

`ifdef R5P_LSU_MISALIGNED_EN
  logic           split;
  logic [DSW-1:0] sel1;
  logic           split_q;
  logic           cap_q;
  logic [DDW-1:0] buf_q;
  logic [DSW-1:0] sel1_q;
  logic [DDW-1:0] wdt1_q;

  assign split = (32'(off) + n) > 32'(DSW);

  always_comb begin
    sel1 = '0;
    for (int unsigned i = 0; i < DSW; i++)
      sel1[i] = (i + 32'(DSW)) < (32'(off) + n);
  end

  // beat 0 was buffered; beat 1 is still on the bus
  assign rd_lo = split_q ? buf_q : ls_rdt;
  assign rd_hi = split_q ? ls_rdt : '0;
`else
  logic [DDW-1:0] unused_wr_hi;

  assign unused_wr_hi = wr_hi;
  assign rd_lo = ls_rdt;
  assign rd_hi = '0;
`endif

  r5p_lsu_align #(
    .XW  (XW),
    .DDW (DDW),
    .DWW (DWW)
  ) u_align (
    .wr_off (off),
    .wr_dat (ctl_wdt),
    .wr_lo  (wr_lo),
    .wr_hi  (wr_hi),
    .rd_off (off_q),
    .rd_sz  (sz_q),
    .rd_sg  (sg_q),
    .rd_lo  (rd_lo),
    .rd_hi  (rd_hi),
    .rd_dat (rd_dat)
  );

  assign rsp_vld = (state == RSP);
  assign rsp_err = rsp_vld & err_q;
  assign rsp_rdt = (rsp_vld & ~wen_q & ~err_q) ? rd_dat : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wen_q   <= 1'b0;
      sg_q    <= 1'b0;
      err_q   <= 1'b0;
      sz_q    <= SZ_B;
      off_q   <= '0;
      ls_req  <= 1'b0;
      ls_wen  <= 1'b0;
      ls_adr  <= '0;
      ls_sel  <= '0;
      ls_wdt  <= '0;
`ifdef R5P_LSU_MISALIGNED_EN
      split_q <= 1'b0;
      cap_q   <= 1'b0;
      buf_q   <= '0;
      sel1_q  <= '0;
      wdt1_q  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (ctl_vld & ctl_rdy) begin
            wen_q <= ctl_wen;
            sg_q  <= ctl_sg;
            sz_q  <= ls_sz_t'(ctl_sz);
            off_q <= off;
            err_q <= err;
            if (err) begin
              state <= RSP;
            end else begin
              ls_req <= 1'b1;
              ls_wen <= ctl_wen;
              ls_adr <= DAW'(ctl_adr) & AMSK;
              ls_sel <= DSW'(opsel(ctl_sz, 32'(off), DSW));
              ls_wdt <= wr_lo;
              state  <= B0;
`ifdef R5P_LSU_MISALIGNED_EN
              split_q <= split;
              sel1_q  <= sel1;
              wdt1_q  <= wr_hi;
`endif
            end
          end
        end
        B0: begin
          if (ls_ack) begin
`ifdef R5P_LSU_MISALIGNED_EN
            if (split_q) begin
              ls_adr <= ls_adr + DAW'(DSW);
              ls_sel <= sel1_q;
              ls_wdt <= wdt1_q;
              cap_q  <= 1'b1;
              state  <= B1;
            end else begin
              ls_req <= 1'b0;
              state  <= RSP;
            end
`else
            ls_req <= 1'b0;
            state  <= RSP;
`endif
          end
        end
`ifdef R5P_LSU_MISALIGNED_EN
        B1: begin
          if (cap_q) begin
            buf_q <= ls_rdt;
            cap_q <= 1'b0;
          end
          if (ls_ack) begin
            ls_req <= 1'b0;
            state  <= RSP;
          end
        end
`endif
        RSP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r5p_lsu.sv
// tb_r5p_lsu: directed checks of r5p_lsu with XW=DDW=32.
// Split/wrap scenarios follow R5P_LSU_MISALIGNED_EN as built.
module tb_r5p_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ctl_vld = 1'b0;
  logic        ctl_rdy;
  logic        ctl_wen = 1'b0;
  logic [2:0]  ctl_sz = 3'd0;
  logic        ctl_sg = 1'b0;
  logic [31:0] ctl_adr = '0;
  logic [31:0] ctl_wdt = '0;
  logic        rsp_vld;
  logic        rsp_err;
  logic [31:0] rsp_rdt;
  logic        ls_req;
  logic        ls_wen;
  logic [31:0] ls_adr;
  logic [3:0]  ls_sel;
  logic [31:0] ls_wdt;
  logic [31:0] ls_rdt = '0;
  logic        ls_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  r5p_lsu #(.XW(32), .DAW(32), .DDW(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctl_vld (ctl_vld),
    .ctl_rdy (ctl_rdy),
    .ctl_wen (ctl_wen),
    .ctl_sz  (ctl_sz),
    .ctl_sg  (ctl_sg),
    .ctl_adr (ctl_adr),
    .ctl_wdt (ctl_wdt),
    .rsp_vld (rsp_vld),
    .rsp_err (rsp_err),
    .rsp_rdt (rsp_rdt),
    .ls_req  (ls_req),
    .ls_wen  (ls_wen),
    .ls_adr  (ls_adr),
    .ls_sel  (ls_sel),
    .ls_wdt  (ls_wdt),
    .ls_rdt  (ls_rdt),
    .ls_ack  (ls_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [2:0] sz,
                       input logic sg, input logic [31:0] adr,
                       input logic [31:0] wdt);
    ctl_vld = 1'b1;
    ctl_wen = wen;
    ctl_sz  = sz;
    ctl_sg  = sg;
    ctl_adr = adr;
    ctl_wdt = wdt;
    tick();
    ctl_vld = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (ctl_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy got %h exp 0", ctl_rdy); end
    checks++; if (ls_req !== 1'b0) begin errors++; $display("FAIL rst_req got %h exp 0", ls_req); end
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %h exp 0", rsp_vld); end
    checks++; if ({ls_wen, ls_adr, ls_sel, ls_wdt} !== '0) begin errors++; $display("FAIL rst_bus got %h/%h/%h exp 0", ls_adr, ls_sel, ls_wdt); end
    checks++; if ({rsp_err, rsp_rdt} !== '0) begin errors++; $display("FAIL rst_rsp got %h/%h exp 0", rsp_err, rsp_rdt); end
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++; if (ctl_rdy !== 1'b1) begin errors++; $display("FAIL rst_rel_rdy got %h exp 1", ctl_rdy); end
  endtask

  task automatic test_store;
    ctl_vld = 1'b1;
    ctl_wen = 1'b1;
    ctl_sz  = 3'd2;
    ctl_adr = 32'h100;
    ctl_wdt = 32'hDEADBEEF;
    #1;
    checks++; if (ctl_rdy !== 1'b1) begin errors++; $display("FAIL sw_rdy got %h exp 1", ctl_rdy); end
    tick();
    ctl_vld = 1'b0;
    checks++; if (ls_req !== 1'b1 || ls_wen !== 1'b1) begin errors++; $display("FAIL sw_req got %h/%h exp 1/1", ls_req, ls_wen); end
    checks++; if (ls_adr !== 32'h100) begin errors++; $display("FAIL sw_adr got %h exp 00000100", ls_adr); end
    checks++; if (ls_sel !== 4'b1111) begin errors++; $display("FAIL sw_sel got %b exp 1111", ls_sel); end
    checks++; if (ls_wdt !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdt got %h exp deadbeef", ls_wdt); end
    checks++; if (rsp_vld !== 1'b0 || ctl_rdy !== 1'b0) begin errors++; $display("FAIL sw_b0 vld/rdy got %h/%h exp 0/0", rsp_vld, ctl_rdy); end
    ls_ack = 1'b1;
    tick();
    ls_ack = 1'b0;
    checks++; if (rsp_vld !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL sw_rsp vld/err got %h/%h exp 1/0", rsp_vld, rsp_err); end
    checks++; if (rsp_rdt !== 32'h0 || ls_req !== 1'b0) begin errors++; $display("FAIL sw_rsp rdt/req got %h/%h exp 0/0", rsp_rdt, ls_req); end
    tick();
    checks++; if (rsp_vld !== 1'b0 || ctl_rdy !== 1'b1) begin errors++; $display("FAIL sw_end vld/rdy got %h/%h exp 0/1", rsp_vld, ctl_rdy); end
  endtask

  task automatic test_byte_load;
    logic [31:0] exp_rdt [2];
    exp_rdt[0] = 32'hFFFFFF80;
    exp_rdt[1] = 32'h00000080;
    for (int k = 0; k < 2; k++) begin
      issue(1'b0, 3'd0, (k == 0), 32'h103, 32'h0);
      checks++; if (ls_adr !== 32'h100 || ls_sel !== 4'b1000) begin errors++; $display("FAIL lb%0d_bus got %h/%b exp 00000100/1000", k, ls_adr, ls_sel); end
      checks++; if (ls_req !== 1'b1 || ls_wen !== 1'b0) begin errors++; $display("FAIL lb%0d_req got %h/%h exp 1/0", k, ls_req, ls_wen); end
      ls_ack = 1'b1;
      tick();
      ls_ack = 1'b0;
      ls_rdt = 32'h80000000;
      #1;
      checks++; if (rsp_vld !== 1'b1) begin errors++; $display("FAIL lb%0d_vld got %h exp 1", k, rsp_vld); end
      checks++; if (rsp_rdt !== exp_rdt[k]) begin errors++; $display("FAIL lb%0d_rdt got %h exp %h", k, rsp_rdt, exp_rdt[k]); end
      tick();
      ls_rdt = '0;
    end
  endtask

  task automatic test_split;
`ifdef R5P_LSU_MISALIGNED_EN
    issue(1'b0, 3'd2, 1'b0, 32'h102, 32'h0);
    checks++; if (ls_adr !== 32'h100 || ls_sel !== 4'b1100) begin errors++; $display("FAIL split_b0 got %h/%b exp 00000100/1100", ls_adr, ls_sel); end
    ls_ack = 1'b1;
    tick();
    ls_rdt = 32'h55660000;
    checks++; if (ls_req !== 1'b1 || ls_adr !== 32'h104 || ls_sel !== 4'b0011) begin errors++; $display("FAIL split_b1 got %h/%h/%b exp 1/00000104/0011", ls_req, ls_adr, ls_sel); end
    checks++; if (rsp_vld !== 1'b0 || ctl_rdy !== 1'b0) begin errors++; $display("FAIL split_b1 vld/rdy got %h/%h exp 0/0", rsp_vld, ctl_rdy); end
    tick();
    ls_ack = 1'b0;
    ls_rdt = 32'h00007788;
    #1;
    checks++; if (rsp_vld !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL split_rsp vld/err got %h/%h exp 1/0", rsp_vld, rsp_err); end
    checks++; if (rsp_rdt !== 32'h77885566) begin errors++; $display("FAIL split_rdt got %h exp 77885566", rsp_rdt); end
    tick();
    ls_rdt = '0;
`else
    issue(1'b0, 3'd2, 1'b0, 32'h102, 32'h0);
    checks++; if (rsp_vld !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL misal_rsp vld/err got %h/%h exp 1/1", rsp_vld, rsp_err); end
    checks++; if (ls_req !== 1'b0 || rsp_rdt !== 32'h0) begin errors++; $display("FAIL misal_req/rdt got %h/%h exp 0/0", ls_req, rsp_rdt); end
    tick();
    checks++; if (rsp_vld !== 1'b0 || ls_req !== 1'b0 || ctl_rdy !== 1'b1) begin errors++; $display("FAIL misal_end got %h/%h/%h exp 0/0/1", rsp_vld, ls_req, ctl_rdy); end
`endif
  endtask

  task automatic test_wait;
    issue(1'b1, 3'd1, 1'b0, 32'h200, 32'h0000ABCD);
    for (int k = 0; k < 3; k++) begin
      checks++; if (ls_req !== 1'b1 || ls_wen !== 1'b1) begin errors++; $display("FAIL wait%0d_req got %h/%h exp 1/1", k, ls_req, ls_wen); end
      checks++; if (ls_adr !== 32'h200 || ls_sel !== 4'b0011 || ls_wdt !== 32'h0000ABCD) begin errors++; $display("FAIL wait%0d_bus got %h/%b/%h exp 00000200/0011/0000abcd", k, ls_adr, ls_sel, ls_wdt); end
      checks++; if (ctl_rdy !== 1'b0 || rsp_vld !== 1'b0) begin errors++; $display("FAIL wait%0d_rdy/vld got %h/%h exp 0/0", k, ctl_rdy, rsp_vld); end
      tick();
    end
    ls_ack = 1'b1;
    tick();
    ls_ack = 1'b0;
    checks++; if (rsp_vld !== 1'b1 || rsp_err !== 1'b0 || ls_req !== 1'b0) begin errors++; $display("FAIL wait_rsp got %h/%h/%h exp 1/0/0", rsp_vld, rsp_err, ls_req); end
    tick();
  endtask

  task automatic test_wrap;
`ifdef R5P_LSU_MISALIGNED_EN
    issue(1'b1, 3'd1, 1'b0, 32'hFFFFFFFF, 32'h0000A1B2);
    checks++; if (ls_adr !== 32'hFFFFFFFC || ls_sel !== 4'b1000 || ls_wdt !== 32'hB2000000) begin errors++; $display("FAIL wrap_b0 got %h/%b/%h exp fffffffc/1000/b2000000", ls_adr, ls_sel, ls_wdt); end
    ls_ack = 1'b1;
    tick();
    checks++; if (ls_adr !== 32'h0 || ls_sel !== 4'b0001 || ls_wdt !== 32'h000000A1) begin errors++; $display("FAIL wrap_b1 got %h/%b/%h exp 00000000/0001/000000a1", ls_adr, ls_sel, ls_wdt); end
    tick();
    ls_ack = 1'b0;
    checks++; if (rsp_vld !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL wrap_rsp got %h/%h exp 1/0", rsp_vld, rsp_err); end
    tick();
`else
    issue(1'b1, 3'd1, 1'b0, 32'hFFFFFFFF, 32'h0000A1B2);
    checks++; if (rsp_vld !== 1'b1 || rsp_err !== 1'b1 || ls_req !== 1'b0) begin errors++; $display("FAIL wrap_err got %h/%h/%h exp 1/1/0", rsp_vld, rsp_err, ls_req); end
    tick();
`endif
  endtask

  task automatic test_reset_mid;
`ifdef R5P_LSU_MISALIGNED_EN
    issue(1'b0, 3'd2, 1'b0, 32'h102, 32'h0);
    ls_ack = 1'b1;
    tick();
    ls_ack = 1'b0;
    ls_rdt = 32'h55660000;
`else
    issue(1'b0, 3'd2, 1'b0, 32'h100, 32'h0);
`endif
    rst = 1'b0;
    #1;
    checks++; if (ls_req !== 1'b0 || rsp_vld !== 1'b0) begin errors++; $display("FAIL mid_rst req/vld got %h/%h exp 0/0", ls_req, rsp_vld); end
    #2;
    rst = 1'b1;
    ls_rdt = '0;
    tick();
    checks++; if (rsp_vld !== 1'b0 || ctl_rdy !== 1'b1) begin errors++; $display("FAIL mid_rel vld/rdy got %h/%h exp 0/1", rsp_vld, ctl_rdy); end
    issue(1'b0, 3'd2, 1'b0, 32'h0, 32'h0);
    checks++; if (ls_req !== 1'b1 || ls_adr !== 32'h0 || ls_sel !== 4'b1111) begin errors++; $display("FAIL mid_lw_bus got %h/%h/%b exp 1/00000000/1111", ls_req, ls_adr, ls_sel); end
    ls_ack = 1'b1;
    tick();
    ls_ack = 1'b0;
    ls_rdt = 32'h13579BDF;
    #1;
    checks++; if (rsp_vld !== 1'b1 || rsp_rdt !== 32'h13579BDF) begin errors++; $display("FAIL mid_lw_rsp got %h/%h exp 1/13579bdf", rsp_vld, rsp_rdt); end
    tick();
    ls_rdt = '0;
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL mid_lw_end got %h exp 0", rsp_vld); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_byte_load();
    test_split();
    test_wait();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
